// File: rtl/avg_det_pkg.sv
// avg_det_pkg: shared types and sizing for avg_threshold_detector.
// Optional macro AVG_DET_PEAK_EN adds a peak field to the event payload.
// The event struct is sized from the package widths below; a top instance
// that overrides DATA_WIDTH/CNT_WIDTH must see matching package values.
package avg_det_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int HOLD_CYCLES = 4;
    localparam int CNT_WIDTH   = 16;

    // Wide enough to hold the saturated value HOLD_CYCLES itself.
    localparam int QUAL_CNT_W  = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        ARM_HIGH = 2'd1,
        HIGH     = 2'd2,
        ARM_LOW  = 2'd3
    } det_state_e;

    typedef struct packed {
        logic                  rise;
        logic [CNT_WIDTH-1:0]  stamp;
`ifdef AVG_DET_PEAK_EN
        logic [DATA_WIDTH-1:0] peak;
`endif
    } det_evt_t;

    // Qualification-counter width for an arbitrary hold length.
    function automatic int qual_cnt_w(input int hold);
        return $clog2(hold + 1);
    endfunction

endpackage

// File: rtl/avg_det_qual_counter.sv
// avg_det_qual_counter: saturating count of consecutive qualifying samples.
// done is combinational: it flags that the current increment is the one
// that reaches HOLD_CYCLES, so the caller can confirm in the same cycle.
module avg_det_qual_counter #(
    parameter int HOLD_CYCLES = 4,
    parameter int CW          = $clog2(HOLD_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic done
);

    logic [CW-1:0] count_d, count_q;

    assign done = inc && (count_q == CW'(HOLD_CYCLES - 1));

    // Clear wins over increment; saturate at HOLD_CYCLES.
    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (inc && (count_q != CW'(HOLD_CYCLES)))
            count_d = count_q + 1'b1;
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

endmodule

// File: rtl/avg_threshold_detector.sv
// avg_threshold_detector: hysteresis level detector with hold-off and a
// single-entry timestamped event output (valid/ready, sticky overflow).
// Optional macro AVG_DET_PEAK_EN adds evt_peak: the maximum sample seen
// from entry into ARM_HIGH through the confirming fall sample.
module avg_threshold_detector
    import avg_det_pkg::*;
#(
    parameter int DATA_WIDTH  = avg_det_pkg::DATA_WIDTH,
    parameter int HOLD_CYCLES = avg_det_pkg::HOLD_CYCLES,
    parameter int CNT_WIDTH   = avg_det_pkg::CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] thr_high,
    input  logic [DATA_WIDTH-1:0] thr_low,
    output logic                  level,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic                  evt_rise,
    output logic [CNT_WIDTH-1:0]  evt_stamp,
`ifdef AVG_DET_PEAK_EN
    output logic [DATA_WIDTH-1:0] evt_peak,
`endif
    output logic                  overflow,
    input  logic                  ovf_clr
);

    localparam int QW = qual_cnt_w(HOLD_CYCLES);

    det_state_e             state_d, state_q;
    logic                   level_d, level_q;
    logic                   evt_valid_d, evt_valid_q;
    det_evt_t               evt_d, evt_q;
    logic                   ovf_d, ovf_q;
    logic [CNT_WIDTH-1:0]   idx_d, idx_q;

    logic q_hi, q_lo, rising_side, qual, q_inc, q_clr, q_done;
    logic pop, fire, drop;

`ifdef AVG_DET_PEAK_EN
    logic [DATA_WIDTH-1:0]  peak_d, peak_q, peak_max;
`endif

    assign q_hi        = (data_in >= thr_high);
    assign q_lo        = (data_in <= thr_low);
    assign rising_side = (state_q == LOW) || (state_q == ARM_HIGH);
    assign qual        = rising_side ? q_hi : q_lo;
    assign q_inc       = in_valid && qual;
    assign q_clr       = in_valid && (!qual || q_done);
    assign fire        = q_done;
    assign pop         = evt_valid_q && evt_ready;
    assign drop        = fire && evt_valid_q && !evt_ready;

    avg_det_qual_counter #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .CW          (QW)
    ) u_qual (
        .clk  (clk),
        .rst  (rst),
        .clr  (q_clr),
        .inc  (q_inc),
        .done (q_done)
    );

    // Next state: only accepted samples move the FSM; a miss aborts the arm.
    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            case (state_q)
                LOW, ARM_HIGH: state_d = !q_hi ? LOW  : (q_done ? HIGH : ARM_HIGH);
                HIGH, ARM_LOW: state_d = !q_lo ? HIGH : (q_done ? LOW  : ARM_LOW);
                default:       state_d = LOW;
            endcase
        end
        level_d = (state_d == HIGH) || (state_d == ARM_LOW);
        idx_d   = in_valid ? idx_q + 1'b1 : idx_q;
    end

`ifdef AVG_DET_PEAK_EN
    assign peak_max = (data_in > peak_q) ? data_in : peak_q;

    // Peak tracking: start on arm-high, clear on abort or fall confirmation.
    always_comb begin
        peak_d = peak_q;
        if (in_valid) begin
            if (rising_side) peak_d = q_hi ? peak_max : '0;
            else             peak_d = (q_lo && q_done) ? '0 : peak_max;
        end
    end
`endif

    // Event slot: load on fire unless occupied and not draining; else pop.
    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_d       = evt_q;
        if (fire && !drop) begin
            evt_valid_d = 1'b1;
            evt_d.rise  = rising_side;
            evt_d.stamp = idx_q;
`ifdef AVG_DET_PEAK_EN
            evt_d.peak  = rising_side ? '0 : peak_max;
`endif
        end else if (pop) begin
            evt_valid_d = 1'b0;
        end
        ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    end

    // State registers; reset discards any pending event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOW;
            level_q     <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_q       <= '0;
            ovf_q       <= 1'b0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            evt_valid_q <= evt_valid_d;
            evt_q       <= evt_d;
            ovf_q       <= ovf_d;
            idx_q       <= idx_d;
        end
    end

`ifdef AVG_DET_PEAK_EN
    // Peak register.
    always_ff @(posedge clk) begin
        if (rst) peak_q <= '0;
        else     peak_q <= peak_d;
    end
    assign evt_peak = evt_q.peak;
`endif

    assign level     = level_q;
    assign evt_valid = evt_valid_q;
    assign evt_rise  = evt_q.rise;
    assign evt_stamp = evt_q.stamp;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_avg_threshold_detector.sv
// Testbench for avg_threshold_detector: directed scenarios plus a
// randomized run against a behavioural model (run-length hysteresis).
module tb_avg_threshold_detector;

    localparam int DW   = 8;
    localparam int HOLD = 4;
    localparam int CW   = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] thr_high = 8'd30;
    logic [DW-1:0] thr_low  = 8'd10;
    logic          level, evt_valid, evt_rise, overflow;
    logic          evt_ready = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [CW-1:0] evt_stamp;
`ifdef AVG_DET_PEAK_EN
    logic [DW-1:0] evt_peak;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit            m_level, m_vld, m_rise, m_ovf;
    int            m_run;
    logic [CW-1:0] m_idx, m_stamp;
    logic [DW-1:0] m_pk, m_epk;

    avg_threshold_detector #(
        .DATA_WIDTH (DW),
        .HOLD_CYCLES(HOLD),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .in_valid (in_valid),
        .thr_high (thr_high),
        .thr_low  (thr_low),
        .level    (level),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_rise (evt_rise),
        .evt_stamp(evt_stamp),
`ifdef AVG_DET_PEAK_EN
        .evt_peak (evt_peak),
`endif
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    // Model: a level flips after HOLD consecutive accepted samples that
    // qualify toward the opposite level; one-deep event slot.
    function automatic void model_edge();
        bit            fire = 0, frise = 0, q, pop, drop;
        logic [CW-1:0] fstamp = '0;
        logic [DW-1:0] fpk = '0, mx;
        if (rst) begin
            m_level = 0; m_run = 0; m_idx = '0; m_vld = 0; m_rise = 0;
            m_stamp = '0; m_ovf = 0; m_pk = '0; m_epk = '0;
            return;
        end
        pop = m_vld && evt_ready;
        if (in_valid) begin
            q  = m_level ? (data_in <= thr_low) : (data_in >= thr_high);
            mx = (data_in > m_pk) ? data_in : m_pk;
            if (!m_level) m_pk = q ? mx : '0;
            else          m_pk = mx;
            m_run = q ? m_run + 1 : 0;
            if (m_run == HOLD) begin
                fire  = 1;
                frise = !m_level;
                fpk   = m_level ? m_pk : '0;
                if (m_level) m_pk = '0;
                m_level = !m_level;
                m_run   = 0;
            end
            fstamp = m_idx;
            m_idx  = m_idx + 1'b1;
        end
        drop = fire && m_vld && !pop;
        if (fire && !drop) begin
            m_vld = 1; m_rise = frise; m_stamp = fstamp; m_epk = fpk;
        end else if (pop) begin
            m_vld = 0;
        end
        if (drop)         m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
    endfunction

    task automatic step(input logic v, input logic [DW-1:0] d,
                        input logic r, input logic c);
        in_valid = v; data_in = d; evt_ready = r; ovf_clr = c;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b1, 8'd99, 1'b1, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b1, 8'd200, 1'b0, 1'b0);
        checks++;
        if ({level, evt_valid, evt_rise, evt_stamp, overflow} !== {1'b0, 1'b0, 1'b0, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset: got %b/%b/%b/%0d/%b expected 0/0/0/0/0",
                     level, evt_valid, evt_rise, evt_stamp, overflow);
        end
        rst = 1'b0;
    endtask

    task automatic test_rise();
        thr_high = 8'd30; thr_low = 8'd10;
        do_reset();
        step(1, 8'd0, 1, 0); step(1, 8'd0, 1, 0);
        step(1, 8'd35, 1, 0); step(1, 8'd35, 1, 0); step(1, 8'd35, 1, 0);
        checks++;
        if ({level, evt_valid} !== 2'b00) begin
            errors++; $display("FAIL rise_pre: got %b%b expected 00", level, evt_valid);
        end
        step(1, 8'd35, 1, 0);
        checks++;
        if ({level, evt_valid, evt_rise, evt_stamp} !== {1'b1, 1'b1, 1'b1, 16'd5}) begin
            errors++;
            $display("FAIL rise_evt: got %b/%b/%b/%0d expected 1/1/1/5",
                     level, evt_valid, evt_rise, evt_stamp);
        end
        step(0, 8'd0, 1, 0);
        checks++;
        if ({level, evt_valid} !== 2'b10) begin
            errors++; $display("FAIL rise_pop: got %b%b expected 10", level, evt_valid);
        end
    endtask

    task automatic test_glitch();
        logic [DW-1:0] seq [7] = '{8'd35, 8'd35, 8'd35, 8'd5, 8'd35, 8'd35, 8'd35};
        do_reset();
        foreach (seq[i]) begin
            step(1, seq[i], 1, 0);
            checks++;
            if ({level, evt_valid} !== 2'b00) begin
                errors++; $display("FAIL glitch[%0d]: got %b%b expected 00", i, level, evt_valid);
            end
        end
    endtask

    task automatic test_fall();
        logic [DW-1:0] seq [5] = '{8'd60, 8'd10, 8'd8, 8'd10, 8'd9};
        do_reset();
        repeat (4) step(1, 8'd35, 1, 0);
        foreach (seq[i]) step(1, seq[i], 1, 0);
        checks++;
        if ({level, evt_valid, evt_rise, evt_stamp} !== {1'b0, 1'b1, 1'b0, 16'd8}) begin
            errors++;
            $display("FAIL fall_evt: got %b/%b/%b/%0d expected 0/1/0/8",
                     level, evt_valid, evt_rise, evt_stamp);
        end
`ifdef AVG_DET_PEAK_EN
        checks++;
        if (evt_peak !== 8'd60) begin
            errors++; $display("FAIL fall_peak: got %0d expected 60", evt_peak);
        end
`endif
    endtask

    task automatic test_overflow();
        do_reset();
        repeat (4) step(1, 8'd35, 0, 0);
        repeat (4) step(1, 8'd5, 0, 0);
        checks++;
        if ({level, evt_valid, evt_rise, evt_stamp, overflow} !== {1'b0, 1'b1, 1'b1, 16'd3, 1'b1}) begin
            errors++;
            $display("FAIL ovf_drop: got %b/%b/%b/%0d/%b expected 0/1/1/3/1",
                     level, evt_valid, evt_rise, evt_stamp, overflow);
        end
        step(0, 8'd0, 0, 1);
        checks++;
        if ({overflow, evt_valid} !== 2'b01) begin
            errors++; $display("FAIL ovf_clr: got %b%b expected 01", overflow, evt_valid);
        end
        step(0, 8'd0, 1, 0);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++; $display("FAIL ovf_drain: got %b expected 0", evt_valid);
        end
    endtask

    task automatic test_valid_toggle();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(i[0] == 1'b0, 8'd35, 0, 0);
            checks++;
            if (i < 6 && evt_valid !== 1'b0) begin
                errors++; $display("FAIL toggle_early[%0d]: got %b expected 0", i, evt_valid);
            end else if (i >= 6 && {evt_valid, evt_stamp} !== {1'b1, 16'd3}) begin
                errors++; $display("FAIL toggle_evt[%0d]: got %b/%0d expected 1/3", i, evt_valid, evt_stamp);
            end
        end
    endtask

    task automatic test_reset_mid_arm();
        do_reset();
        repeat (3) step(1, 8'd35, 1, 0);
        rst = 1'b1;
        step(1, 8'd35, 1, 0);
        rst = 1'b0;
        checks++;
        if ({level, evt_valid, evt_rise, evt_stamp, overflow} !== {1'b0, 1'b0, 1'b0, 16'd0, 1'b0}) begin
            errors++; $display("FAIL midrst: got %b/%b/%b/%0d/%b expected 0/0/0/0/0",
                               level, evt_valid, evt_rise, evt_stamp, overflow);
        end
        repeat (3) step(1, 8'd35, 1, 0);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_quiet: got %b expected 0", evt_valid);
        end
        step(1, 8'd35, 1, 0);
        checks++;
        if ({evt_valid, evt_rise, evt_stamp} !== {1'b1, 1'b1, 16'd3}) begin
            errors++; $display("FAIL midrst_evt: got %b/%b/%0d expected 1/1/3", evt_valid, evt_rise, evt_stamp);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                thr_high = 8'($urandom_range(90, 170));
                thr_low  = 8'($urandom_range(60, 140));
            end
            rst = ($urandom_range(0, 499) == 0);
            step($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
            rst = 1'b0;
            checks++;
            if ({level, evt_valid, evt_rise, evt_stamp, overflow} !==
                {m_level, m_vld, m_rise, m_stamp, m_ovf}) begin
                errors++;
                $display("FAIL random[%0d]: got %b/%b/%b/%0d/%b expected %b/%b/%b/%0d/%b", i,
                         level, evt_valid, evt_rise, evt_stamp, overflow,
                         m_level, m_vld, m_rise, m_stamp, m_ovf);
            end
`ifdef AVG_DET_PEAK_EN
            checks++;
            if (evt_peak !== m_epk) begin
                errors++; $display("FAIL random_peak[%0d]: got %0d expected %0d", i, evt_peak, m_epk);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_glitch();
        test_fall();
        test_overflow();
        test_valid_toggle();
        test_reset_mid_arm();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/avg_threshold_detector.md
Name: avg_threshold_detector

Overview:
Downstream consumer of the moving-average filter output. Applies hysteresis thresholds to the filtered sample stream and requires a configurable number of consecutive qualifying samples before it changes level. Each confirmed level change is emitted as a timestamped event over a valid/ready handshake to the control/logging stage.

Parameters:
DATA_WIDTH, 8, width of filtered samples and thresholds (matches filter DATA_WIDTH)
HOLD_CYCLES, 4, consecutive qualifying valid samples needed to confirm a transition (>=1)
CNT_WIDTH, 16, width of free-running sample index / event timestamp

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
data_in  input  DATA_WIDTH  filtered sample (unsigned), from filter data_out
in_valid  input  1  data_in is a new sample this cycle
thr_high  input  DATA_WIDTH  rise threshold; qualifies when data_in >= thr_high
thr_low  input  DATA_WIDTH  fall threshold; qualifies when data_in <= thr_low
level  output  1  confirmed hysteresis level (0 = LOW, 1 = HIGH)
evt_valid  output  1  event pending
evt_ready  input  1  consumer accepts event
evt_rise  output  1  1 = LOW->HIGH event, 0 = HIGH->LOW event
evt_stamp  output  CNT_WIDTH  sample index that completed qualification
overflow  output  1  sticky: an event was dropped
ovf_clr  input  1  clears overflow

Behaviour:
- Reset (rst=1 at edge): state LOW, level 0, evt_valid 0, evt_rise 0, evt_stamp 0, overflow 0, qual counter 0, sample index 0. A pending event is discarded; reset has priority over all inputs.
- A sample is accepted at an edge with in_valid=1. With in_valid=0, state, counters and index hold.
- Sample index increments per accepted sample and wraps from 2^CNT_WIDTH-1 to 0. The stamp is the index value before the increment, so the first sample after reset is index 0.
- FSM states: LOW, ARM_HIGH, HIGH, ARM_LOW.
  - LOW: qualifying (>= thr_high) sample -> ARM_HIGH with count=1. If HOLD_CYCLES=1, go directly to HIGH and fire the event.
  - ARM_HIGH: qualifying sample -> count+1. When count reaches HOLD_CYCLES -> HIGH and fire a rise event. Non-qualifying sample -> LOW, count=0.
  - HIGH and ARM_LOW: mirror of LOW and ARM_HIGH, using the <= thr_low test and firing a fall event.
- level equals 1 in HIGH and ARM_LOW, 0 in LOW and ARM_HIGH. It updates at the same edge as the confirming sample.
- Event latency: evt_valid goes to 1 at the edge that accepts the HOLD_CYCLES-th qualifying sample (0 cycles after acceptance).
- Handshake: payload is stable while evt_valid=1 and evt_ready=0. A pop occurs when evt_valid and evt_ready are both 1 at an edge.
- Simultaneous pop and new event: the new event loads and evt_valid stays 1.
- New event while pending and not popped: the new event is dropped, overflow is set to 1, and the FSM/level still transition.
- ovf_clr=1 clears overflow. If a drop and ovf_clr occur at the same edge, set wins.
- Thresholds are sampled every cycle. Changing them mid-arm affects only later samples; the count is not reset.
- thr_low >= thr_high is legal; the rules above apply unchanged.

Optional Feature:
AVG_DET_PEAK_EN
- Defined: adds output evt_peak[DATA_WIDTH]. A peak register tracks the maximum accepted sample from entry into ARM_HIGH through the confirming fall sample. A fall event carries that maximum; a rise event carries 0. The peak register clears on fall confirmation, on ARM_HIGH abort, and on rst.
- Undefined: no port and no register.

Decomposition:
- Package avg_det_pkg holds:
  - state enum (LOW, ARM_HIGH, HIGH, ARM_LOW)
  - event struct (rise, stamp, optional peak)
  - localparam for qualification-counter width, $clog2(HOLD_CYCLES+1)
- One sub-module, avg_det_qual_counter, provides saturating consecutive-qualify counter with clear/inc/done.

Test Plan:
1. HOLD=4, thr_high=30, thr_low=10, evt_ready=1; samples 0,0,35,35,35,35 -> at 6th edge: level=1, evt_valid=1, evt_rise=1, evt_stamp=5; popped next cycle.
2. Glitch: 35,35,35,5,35,35,35 -> no event, level stays 0; the 5 returns FSM to LOW.
3. From HIGH, samples 60,10,8,10,9 -> fall event with evt_rise=0 and stamp of the 9. With AVG_DET_PEAK_EN: evt_peak=60.
4. evt_ready=0; force rise then fall -> payload stays the rise event, overflow=1, level=0. Pulse ovf_clr -> overflow=0.
5. Qualifying samples with in_valid toggling 1,0,1,0,... -> event only after the 4th valid sample; stamps count valid samples only.
6. rst pulsed after 3 qualifying samples in ARM_HIGH -> all outputs reset values. The next 3 qualifying samples fire nothing; the 4th fires with stamp=3.
